// File: rtl/countdown_timer.sv
// Four-digit MM:SS BCD countdown register: right-entry shift of keyed digits in
// entry mode, one BCD decrement per rising edge of pgt_1hz in run mode.
module countdown_timer (
   input  logic       clk,
   input  logic       clearn,
   input  logic       enablen,
   input  logic       load,
   input  logic [3:0] digit,
   input  logic       pgt_1hz,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       zero,
   output logic       running,
   output logic       done
);

   logic       load_q, tick_q;
   logic [3:0] mt_q, mo_q, st_q, so_q;
   logic [3:0] mt_d, mo_d, st_d, so_d;
   logic       zero_q, zero_d;
   logic       done_q, done_d;
   logic       load_rise, tick_rise, dec;

   assign load_rise = load & ~load_q;
   assign tick_rise = pgt_1hz & ~tick_q;

   always_comb begin
      mt_d = mt_q;
      mo_d = mo_q;
      st_d = st_q;
      so_d = so_q;
      dec  = 1'b0;
      if (!enablen && load_rise && (digit <= 4'd9)) begin
         mt_d = mo_q;
         mo_d = st_q;
         st_d = so_q;
         so_d = digit;
      end else if (enablen && tick_rise && !zero_q) begin
         dec = 1'b1;
         if (so_q != 4'd0) begin
            so_d = so_q - 4'd1;
         end else if (st_q != 4'd0) begin
            so_d = 4'd9;
            st_d = st_q - 4'd1;
         end else begin
            // Seconds are 00 and zero_q is clear, so the minutes must be nonzero.
            so_d = 4'd9;
            st_d = 4'd5;
            if (mo_q != 4'd0) begin
               mo_d = mo_q - 4'd1;
            end else begin
               mo_d = 4'd9;
               mt_d = mt_q - 4'd1;
            end
         end
      end
      zero_d = (mt_d == 4'd0) && (mo_d == 4'd0) && (st_d == 4'd0) && (so_d == 4'd0);
      done_d = dec && zero_d;
   end

   always_ff @(posedge clk) begin
      if (!clearn) begin
         // Edge history resets high so a level held across release is not an edge.
         load_q <= 1'b1;
         tick_q <= 1'b1;
         mt_q   <= '0;
         mo_q   <= '0;
         st_q   <= '0;
         so_q   <= '0;
         zero_q <= 1'b1;
         done_q <= 1'b0;
      end else begin
         load_q <= load;
         tick_q <= pgt_1hz;
         mt_q   <= mt_d;
         mo_q   <= mo_d;
         st_q   <= st_d;
         so_q   <= so_d;
         zero_q <= zero_d;
         done_q <= done_d;
      end
   end

   assign min_tens = mt_q;
   assign min_ones = mo_q;
   assign sec_tens = st_q;
   assign sec_ones = so_q;
   assign zero     = zero_q;
   assign done     = done_q;
   assign running  = enablen & ~zero_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven and scoreboarded checks of countdown_timer: entry shift, invalid
// digits, BCD borrow, 00:99 countdown, terminal count and reset behaviour.
module tb_countdown_timer;

   localparam logic [1:0] OP_PRESS = 2'd0;
   localparam logic [1:0] OP_TICK  = 2'd1;
   localparam logic [1:0] OP_MODE  = 2'd2;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  d;
      logic [15:0] exp;
      logic        zero;
      int          ndone;
   } vec_t;

   typedef struct {
      logic [15:0] exp;
      logic        zero;
      logic        run;
      int          ndone;
   } sb_t;

   logic       clk = 1'b0;
   logic       clearn = 1'b1;
   logic       enablen = 1'b0;
   logic       load = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       pgt_1hz = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       zero, running, done;

   int   tests = 0;
   int   failed = 0;
   logic en_model = 1'b0;
   vec_t tbl[$];
   sb_t  sb[$];

   countdown_timer dut (
      .clk      (clk),
      .clearn   (clearn),
      .enablen  (enablen),
      .load     (load),
      .digit    (digit),
      .pgt_1hz  (pgt_1hz),
      .min_tens (min_tens),
      .min_ones (min_ones),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones),
      .zero     (zero),
      .running  (running),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [15:0] count_now();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   task automatic addv(input logic [1:0] op, input logic [3:0] d, input logic [15:0] exp,
                       input logic z, input int nd);
      vec_t v;
      v.op = op; v.d = d; v.exp = exp; v.zero = z; v.ndone = nd;
      tbl.push_back(v);
   endtask

   task automatic wait_count(input int n, inout int dcnt);
      repeat (n) begin
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      sb_t e;
      sb_t got;
      int  dcnt;
      logic first;
      dcnt  = 0;
      first = 1'b0;
      if (v.op == OP_MODE) en_model = v.d[0];
      e.exp = v.exp; e.zero = v.zero; e.run = en_model & ~v.zero; e.ndone = v.ndone;
      sb.push_back(e);
      case (v.op)
         OP_PRESS: begin
            @(negedge clk);
            load = 1'b1; digit = v.d;
            wait_count(10, dcnt);
            load = 1'b0;
            wait_count(3, dcnt);
         end
         OP_TICK: begin
            @(negedge clk);
            pgt_1hz = 1'b1;
            @(negedge clk);
            first = done;
            if (done === 1'b1) dcnt++;
            wait_count(4, dcnt);
            pgt_1hz = 1'b0;
            wait_count(4, dcnt);
         end
         default: begin
            @(negedge clk);
            enablen = v.d[0];
            wait_count(2, dcnt);
         end
      endcase
      got = sb.pop_front();
      check({name, " count"}, count_now(), got.exp);
      check({name, " zero"}, {15'd0, zero}, {15'd0, got.zero});
      check({name, " running"}, {15'd0, running}, {15'd0, got.run});
      check({name, " done pulses"}, dcnt[15:0], got.ndone[15:0]);
      if (v.op == OP_TICK && got.ndone == 1)
         check({name, " done timing"}, {15'd0, first}, 16'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clearn = 1'b0; load = 1'b0; pgt_1hz = 1'b0; enablen = 1'b0;
      en_model = 1'b0;
      repeat (2) @(negedge clk);
      clearn = 1'b1;
      @(negedge clk);
   endtask

   task automatic step(input logic [1:0] op, input logic [3:0] d, input logic [15:0] exp,
                       input logic z, input int nd, input string name);
      vec_t v;
      v.op = op; v.d = d; v.exp = exp; v.zero = z; v.ndone = nd;
      run_vec(v, name);
   endtask

   initial begin
      // Reset with a key held: no capture until load falls and rises again.
      @(negedge clk);
      clearn = 1'b0; load = 1'b1; digit = 4'd5;
      repeat (3) @(negedge clk);
      check("reset count", count_now(), 16'h0000);
      check("reset zero", {15'd0, zero}, 16'd1);
      check("reset done", {15'd0, done}, 16'd0);
      clearn = 1'b1;
      repeat (5) @(negedge clk);
      check("held key after reset", count_now(), 16'h0000);
      load = 1'b0;
      @(negedge clk);
      step(OP_PRESS, 4'd5, 16'h0005, 1'b0, 0, "re-press after reset");

      // Main table: entry, invalid digit, countdown, borrows, mode freezes.
      do_reset();
      addv(OP_PRESS, 4'd1, 16'h0001, 1'b0, 0);
      addv(OP_PRESS, 4'd2, 16'h0012, 1'b0, 0);
      addv(OP_PRESS, 4'd3, 16'h0123, 1'b0, 0);
      addv(OP_PRESS, 4'd4, 16'h1234, 1'b0, 0);
      addv(OP_PRESS, 4'd7, 16'h2347, 1'b0, 0);
      addv(OP_PRESS, 4'hC, 16'h2347, 1'b0, 0);
      addv(OP_TICK,  4'd0, 16'h2347, 1'b0, 0);
      addv(OP_PRESS, 4'd0, 16'h3470, 1'b0, 0);
      addv(OP_PRESS, 4'd1, 16'h4701, 1'b0, 0);
      addv(OP_PRESS, 4'd0, 16'h7010, 1'b0, 0);
      addv(OP_PRESS, 4'd0, 16'h0100, 1'b0, 0);
      addv(OP_MODE,  4'd1, 16'h0100, 1'b0, 0);
      addv(OP_TICK,  4'd0, 16'h0059, 1'b0, 0);
      addv(OP_TICK,  4'd0, 16'h0058, 1'b0, 0);
      addv(OP_PRESS, 4'd3, 16'h0058, 1'b0, 0);
      addv(OP_MODE,  4'd0, 16'h0058, 1'b0, 0);
      addv(OP_PRESS, 4'd9, 16'h0589, 1'b0, 0);
      addv(OP_MODE,  4'd1, 16'h0589, 1'b0, 0);
      addv(OP_TICK,  4'd0, 16'h0588, 1'b0, 0);
      addv(OP_MODE,  4'd0, 16'h0588, 1'b0, 0);
      addv(OP_PRESS, 4'd1, 16'h5881, 1'b0, 0);
      addv(OP_PRESS, 4'd0, 16'h8810, 1'b0, 0);
      addv(OP_PRESS, 4'd0, 16'h8100, 1'b0, 0);
      addv(OP_PRESS, 4'd0, 16'h1000, 1'b0, 0);
      addv(OP_MODE,  4'd1, 16'h1000, 1'b0, 0);
      addv(OP_TICK,  4'd0, 16'h0959, 1'b0, 0);
      for (int i = 0; i < tbl.size(); i++)
         run_vec(tbl[i], $sformatf("vec%0d", i));

      // 00:99 counts as 99 ticks.
      do_reset();
      step(OP_PRESS, 4'd9, 16'h0009, 1'b0, 0, "s99 key1");
      step(OP_PRESS, 4'd9, 16'h0099, 1'b0, 0, "s99 key2");
      step(OP_MODE,  4'd1, 16'h0099, 1'b0, 0, "s99 run");
      for (int k = 1; k <= 99; k++) begin
         int r;
         r = 99 - k;
         step(OP_TICK, 4'd0, {8'h00, 4'(r / 10), 4'(r % 10)}, (r == 0), (r == 0) ? 1 : 0,
              $sformatf("s99 tick%0d", k));
      end

      // Terminal count from 00:02 with an entered 00:00 never raising done.
      do_reset();
      step(OP_PRESS, 4'd0, 16'h0000, 1'b1, 0, "enter zero");
      step(OP_PRESS, 4'd2, 16'h0002, 1'b0, 0, "term load");
      step(OP_MODE,  4'd1, 16'h0002, 1'b0, 0, "term run");
      step(OP_TICK,  4'd0, 16'h0001, 1'b0, 0, "term tick1");
      step(OP_TICK,  4'd0, 16'h0000, 1'b1, 1, "term tick2");
      step(OP_TICK,  4'd0, 16'h0000, 1'b1, 0, "term tick3");
      step(OP_PRESS, 4'd6, 16'h0000, 1'b1, 0, "term load ignored");

      // Reset mid-count wins over a pending tick.
      step(OP_MODE,  4'd0, 16'h0000, 1'b1, 0, "mid entry");
      step(OP_PRESS, 4'd3, 16'h0003, 1'b0, 0, "mid load");
      step(OP_MODE,  4'd1, 16'h0003, 1'b0, 0, "mid run");
      @(negedge clk);
      clearn = 1'b0; pgt_1hz = 1'b1;
      @(negedge clk);
      clearn = 1'b1;
      repeat (3) @(negedge clk);
      check("reset mid-count", count_now(), 16'h0000);
      check("reset mid-count done", {15'd0, done}, 16'd0);
      pgt_1hz = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Receiving end of the keypad input encoder in the P3 timer design. Captures each keyed BCD digit on the rising edge of `load` into a four-digit MM:SS register using right-entry shift. In run mode it decrements that register once per rising edge of `pgt_1hz` until it reaches 00:00. Its outputs feed the display multiplexer and the top-level controller.

## Interface
Parameters:
- none. Digit count fixed at 4; BCD digit width fixed at 4.

Ports:
- `clk`  in  1  system clock; `pgt_1hz` and `load` are synchronous to it.
- `clearn`  in  1  reset, synchronous, active-low.
- `enablen`  in  1  mode select: 0 = entry mode (accept digits), 1 = run mode (count down).
- `load`  in  1  level from the encoder, high while a key is held.
- `digit`  in  4  BCD digit from the encoder, valid while `load` = 1.
- `pgt_1hz`  in  1  1 Hz square wave from the encoder.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  current count in BCD, registered.
- `zero`  out  1  1 when all four digits = 0, registered.
- `running`  out  1  `enablen` & ~`zero`, combinational.
- `done`  out  1  one-`clk` pulse when the count reaches 00:00 by decrement.

## Operation
- Edge detect: `load_q` and `tick_q` register the previous `load` and `pgt_1hz`.
  - `load_rise` = `load` & ~`load_q`.
  - `tick_rise` = `pgt_1hz` & ~`tick_q`.
- Entry, when `enablen` = 0 and `load_rise`:
  - If `digit` ≤ 9: shift left one digit. `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`digit`. The old `min_tens` is discarded.
  - If `digit` > 9: ignore; no change.
  - Only one capture per key press, however long `load` stays high.
- Run, when `enablen` = 1 and `tick_rise` and `zero` = 0, BCD decrement:
  - `sec_ones` > 0: `sec_ones` − 1.
  - Else `sec_tens` > 0: `sec_ones`=9, `sec_tens` − 1.
  - Else minutes nonzero: seconds = 5,9, and the minutes decrement by the same borrow rule (`min_ones`=0 → `min_ones`=9, `min_tens` − 1).
- Seconds tens may be entered > 5 (e.g. 00:99); the decrement handles this correctly (99 s counts as 99 ticks).
- At 00:00 in run mode: no decrement, no wrap; the count holds at 00:00.
- `load_rise` while `enablen` = 1: ignored.
- `tick_rise` while `enablen` = 0: ignored. Because of the mode split, entry and decrement can never occur in the same cycle.
- Mode change mid-count: the count freezes at its current value. Digits entered afterwards shift into that frozen value; there is no implicit clear.

## Timing
- Reset (`clearn` = 0 at a `clk` edge):
  - All digits = 0, `zero` = 1, `done` = 0.
  - `load_q` = 1 and `tick_q` = 1, so a key held or a tick high across reset release causes no capture or decrement.
- Entry latency: digits update at the first `clk` edge where `load` = 1 is sampled with `load_q` = 0. New values are visible after that edge (1 cycle).
- Decrement latency: same, on the first edge sampling `pgt_1hz` = 1 with `tick_q` = 0. Exactly one decrement per `pgt_1hz` period.
- `zero` updates on the same edge as the digits.
- `done` = 1 for exactly the one cycle following the decrement edge that produced 00:00. It is not asserted by reset, or by entering 00:00 as digits.
- Reset mid-count or mid-key: reset wins. Digits go to 0, and any pending edge is dropped.

## Test plan
- Reset: hold `clearn` = 0 with `load` = 1 and `digit` = 5, then release. Required: digits 00:00, `zero` = 1, `done` = 0, and no capture until `load` falls and rises again.
- Entry: `enablen` = 0; press 1, 2, 3, 4, each with `load` held 10 cycles. Required: 00:01 → 00:12 → 01:23 → 12:34, one shift per press. A fifth press of 7 gives 23:47.
- Invalid digit: `digit` = 4'hC with a `load` pulse. Required: no change.
- Countdown: load 01:00, set `enablen` = 1, apply ticks. Required: 00:59 after the first tick and 00:58 after the second.
- 00:99 entry: load 00:99 and run 99 ticks. Required: the count reaches 00:00 after exactly 99 ticks.
- Terminal count: from 00:02, run 3 ticks. Required:
  - 00:01, then 00:00 with `done` high one cycle and `zero` = 1, `running` = 0.
  - Third tick: no change, `done` stays 0.
  - A `load` pulse with `enablen` = 1 has no effect.
